// File: rtl/proc_boot_sequencer.sv
// Boot/run controller: latches per-core start PCs, holds all cores for HOLD_CYCLES, releases them STAGGER apart
// and stops each on halt_req or budget expiry. run[0] rises HOLD_CYCLES+1 edges after start; no backpressure, start ignored while busy.
module proc_boot_sequencer #(
  parameter int NUM_CORES    = 2,
  parameter int PC_WIDTH     = 32,
  parameter int HOLD_CYCLES  = 4,
  parameter int STAGGER      = 3,
  parameter int RUN_CYCLES   = 10,
  parameter int AUTO_RESTART = 0
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          start,
  input  logic [PC_WIDTH-1:0]           pc_base,
  input  logic [PC_WIDTH-1:0]           pc_stride,
  input  logic [NUM_CORES-1:0]          halt_req,
  output logic [NUM_CORES-1:0]          run,
  output logic [NUM_CORES*PC_WIDTH-1:0] startPC,
  output logic                          busy,
  output logic                          done,
  output logic [NUM_CORES-1:0]          timeout
);

  localparam int REL_MAX = (NUM_CORES - 1) * STAGGER;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int RW = (REL_MAX > 0) ? $clog2(REL_MAX + 1) : 1;
  localparam int BW = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] REL_LAST  = RW'(REL_MAX);
  localparam logic [BW-1:0] BUD_LAST  = BW'((RUN_CYCLES > 0) ? RUN_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_RUN, S_DONE} state_t;

  state_t                             state;
  state_t                             state_nxt;
  logic [HW-1:0]                      hold_cnt;
  logic [RW-1:0]                      rel_cnt;
  logic [NUM_CORES-1:0][BW-1:0]       bud_cnt;
  logic [NUM_CORES-1:0][PC_WIDTH-1:0] pc_q;

  logic                 accept;
  logic                 restart;
  logic                 hold_end;
  logic [NUM_CORES-1:0] rel_now;
  logic [NUM_CORES-1:0] expire;
  logic [NUM_CORES-1:0] run_nxt;

  assign startPC = pc_q;

  // Release is aligned to the edge leaving HOLD: core i goes at rel_cnt+1 == i*STAGGER.
  always_comb begin
    accept   = start && (state == S_IDLE || state == S_DONE);
    restart  = (AUTO_RESTART != 0) && (state == S_DONE);
    hold_end = (state == S_HOLD) && (hold_cnt == '0);
    rel_now  = '0;
    expire   = '0;
    run_nxt  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      rel_now[i] = (hold_end && (i * STAGGER == 0)) ||
                   ((state == S_RUN) && ((int'(rel_cnt) + 1) == i * STAGGER));
      expire[i]  = run[i] && (RUN_CYCLES != 0) && (bud_cnt[i] == BUD_LAST);
      run_nxt[i] = rel_now[i] || (run[i] && !halt_req[i] && !expire[i]);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_HOLD;
      S_HOLD: if (hold_end) state_nxt = S_RUN;
      S_RUN:  if (run_nxt == '0 && rel_cnt == REL_LAST) state_nxt = S_DONE;
      S_DONE: if (accept || restart) state_nxt = S_HOLD;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_HOLD) || (state == S_RUN);
    done = (state == S_DONE);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hold_cnt <= '0;
      rel_cnt  <= '0;
      bud_cnt  <= '0;
      pc_q     <= '0;
      run      <= '0;
      timeout  <= '0;
    end else begin
      run <= run_nxt;

      if (accept) begin
        for (int i = 0; i < NUM_CORES; i++) begin
          pc_q[i] <= pc_base + pc_stride * PC_WIDTH'(i);
        end
      end

      if (accept || restart) begin
        hold_cnt <= HOLD_LOAD;
        timeout  <= '0;
      end else begin
        if (state == S_HOLD && hold_cnt != '0) begin
          hold_cnt <= hold_cnt - HW'(1);
        end
        // A halt on the expiry edge wins, so no timeout is recorded.
        timeout <= timeout | (expire & ~halt_req);
      end

      if (state == S_HOLD) begin
        rel_cnt <= '0;
      end else if (state == S_RUN && rel_cnt != REL_LAST) begin
        rel_cnt <= rel_cnt + RW'(1);
      end

      for (int i = 0; i < NUM_CORES; i++) begin
        if (rel_now[i]) begin
          bud_cnt[i] <= '0;
        end else if (run[i] && (RUN_CYCLES != 0) && !expire[i]) begin
          bud_cnt[i] <= bud_cnt[i] + BW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_proc_boot_sequencer.sv
// Directed bench: dut_a uses the default boot parameters, dut_b exercises auto restart with an unlimited budget.
module tb_proc_boot_sequencer;

  localparam int NC = 2;
  localparam int PW = 32;

  logic CLK   = 1'b0;
  logic RESET = 1'b0;

  logic             start_a, start_b;
  logic [PW-1:0]    base_a, stride_a, base_b, stride_b;
  logic [NC-1:0]    halt_a, halt_b;
  logic [NC-1:0]    run_a, run_b, to_a, to_b;
  logic [NC*PW-1:0] pc_a, pc_b;
  logic             busy_a, done_a, busy_b, done_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  proc_boot_sequencer #(
    .NUM_CORES(NC), .PC_WIDTH(PW), .HOLD_CYCLES(4), .STAGGER(3), .RUN_CYCLES(10), .AUTO_RESTART(0)
  ) dut_a (
    .CLK(CLK), .RESET(RESET), .start(start_a), .pc_base(base_a), .pc_stride(stride_a),
    .halt_req(halt_a), .run(run_a), .startPC(pc_a), .busy(busy_a), .done(done_a), .timeout(to_a)
  );

  proc_boot_sequencer #(
    .NUM_CORES(NC), .PC_WIDTH(PW), .HOLD_CYCLES(4), .STAGGER(3), .RUN_CYCLES(0), .AUTO_RESTART(1)
  ) dut_b (
    .CLK(CLK), .RESET(RESET), .start(start_b), .pc_base(base_b), .pc_stride(stride_b),
    .halt_req(halt_b), .run(run_b), .startPC(pc_b), .busy(busy_b), .done(done_b), .timeout(to_b)
  );

  typedef struct {
    int            len;
    logic          start;
    logic [PW-1:0] base;
    logic [PW-1:0] stride;
    logic [NC-1:0] halt;
    logic [NC-1:0] run;
    logic          busy;
    logic          done;
    logic [NC-1:0] to;
    logic [PW-1:0] pc0;
    logic [PW-1:0] pc1;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Inputs apply in the first cycle of a row; expectations hold for every cycle of the row.
    vt[0]  = '{1,  1'b1, 32'h100,  32'h40, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0,    32'h0};
    vt[1]  = '{4,  1'b0, 32'h0,    32'h0,  2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 32'h100,  32'h140};
    vt[2]  = '{3,  1'b0, 32'h0,    32'h0,  2'b00, 2'b01, 1'b1, 1'b0, 2'b00, 32'h100,  32'h140};
    vt[3]  = '{7,  1'b0, 32'h0,    32'h0,  2'b00, 2'b11, 1'b1, 1'b0, 2'b00, 32'h100,  32'h140};
    vt[4]  = '{3,  1'b0, 32'h0,    32'h0,  2'b00, 2'b10, 1'b1, 1'b0, 2'b01, 32'h100,  32'h140};
    vt[5]  = '{2,  1'b0, 32'h0,    32'h0,  2'b00, 2'b00, 1'b0, 1'b1, 2'b11, 32'h100,  32'h140};
    vt[6]  = '{1,  1'b1, 32'h2000, 32'h10, 2'b00, 2'b00, 1'b0, 1'b1, 2'b11, 32'h100,  32'h140};
    vt[7]  = '{4,  1'b0, 32'h0,    32'h0,  2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 32'h2000, 32'h2010};
    vt[8]  = '{2,  1'b0, 32'h0,    32'h0,  2'b00, 2'b01, 1'b1, 1'b0, 2'b00, 32'h2000, 32'h2010};
    vt[9]  = '{1,  1'b0, 32'h0,    32'h0,  2'b01, 2'b01, 1'b1, 1'b0, 2'b00, 32'h2000, 32'h2010};
    vt[10] = '{10, 1'b0, 32'h0,    32'h0,  2'b00, 2'b10, 1'b1, 1'b0, 2'b00, 32'h2000, 32'h2010};
    vt[11] = '{2,  1'b0, 32'h0,    32'h0,  2'b00, 2'b00, 1'b0, 1'b1, 2'b10, 32'h2000, 32'h2010};

    start_a = 1'b0; base_a = '0; stride_a = '0; halt_a = '0;
    start_b = 1'b0; base_b = '0; stride_b = '0; halt_b = '0;

    // Reset with no clock edge yet: outputs must clear asynchronously.
    #1 RESET = 1'b1;
    #1;
    chk("reset_async_a", {run_a, busy_a, done_a, to_a, pc_a}, '0);
    chk("reset_async_b", {run_b, busy_b, done_b, to_b, pc_b}, '0);
    RESET = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      chk($sformatf("idle_quiet.%0d", c),
          {run_a, busy_a, done_a, to_a, pc_a, run_b, busy_b, done_b, to_b}, '0);
    end

    // Full timeout boot, then a halted boot started from DONE.
    for (int r = 0; r < 12; r++) begin
      for (int c = 0; c < vt[r].len; c++) begin
        chk($sformatf("vec%0d.%0d", r, c),
            {run_a, busy_a, done_a, to_a, pc_a},
            {vt[r].run, vt[r].busy, vt[r].done, vt[r].to, vt[r].pc1, vt[r].pc0});
        start_a = (c == 0) ? vt[r].start : 1'b0;
        halt_a  = (c == 0) ? vt[r].halt : 2'b00;
        if (c == 0 && vt[r].start) begin
          base_a   = vt[r].base;
          stride_a = vt[r].stride;
        end
        step();
      end
    end
    start_a = 1'b0;
    halt_a  = '0;

    // PC wrap-around, and a start pulse during HOLD that must be ignored.
    start_a = 1'b1; base_a = 32'hFFFF_FFF0; stride_a = 32'h20;
    step();
    start_a = 1'b0;
    chk("wrap_pc", {busy_a, pc_a}, {1'b1, 32'h0000_0010, 32'hFFFF_FFF0});
    step();
    start_a = 1'b1; base_a = 32'h5555_0000; stride_a = 32'h1;
    step();
    start_a = 1'b0;
    chk("ignore_hold_pc", {busy_a, run_a, pc_a}, {1'b1, 2'b00, 32'h0000_0010, 32'hFFFF_FFF0});
    step();
    chk("ignore_hold_c4", run_a, 2'b00);
    step();
    chk("ignore_hold_c5", run_a, 2'b01);

    // Async reset while core 1 runs and core 0 has already timed out.
    for (int c = 5; c < 16; c++) step();
    chk("pre_reset_c16", {run_a, busy_a, to_a}, {2'b10, 1'b1, 2'b01});
    #2 RESET = 1'b1;
    #1;
    chk("reset_midrun", {run_a, busy_a, done_a, to_a, pc_a}, '0);
    #1 RESET = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("post_reset_idle.%0d", c), {run_a, busy_a, done_a}, '0);
    end
    start_a = 1'b1; base_a = 32'h40; stride_a = 32'h8;
    step();
    start_a = 1'b0;
    chk("reboot_c1", {busy_a, pc_a}, {1'b1, 32'h48, 32'h40});
    for (int c = 1; c < 4; c++) step();
    chk("reboot_c4", run_a, 2'b00);
    step();
    chk("reboot_c5", run_a, 2'b01);
    for (int c = 5; c < 8; c++) step();
    chk("reboot_c8", run_a, 2'b11);

    // Auto restart with unlimited budget: both cores halted at cycle 30.
    start_b = 1'b1; base_b = 32'h300; stride_b = 32'h4;
    for (int cy = 0; cy <= 40; cy++) begin
      halt_b = (cy == 30) ? 2'b11 : 2'b00;
      case (cy)
        4:  chk("ar_hold", {busy_b, run_b}, {1'b1, 2'b00});
        5:  chk("ar_run0", run_b, 2'b01);
        8:  chk("ar_run1", run_b, 2'b11);
        30: chk("ar_unlimited", {run_b, to_b, done_b}, {2'b11, 2'b00, 1'b0});
        31: chk("ar_done", {done_b, busy_b, run_b, to_b}, {1'b1, 1'b0, 2'b00, 2'b00});
        32: chk("ar_rehold", {done_b, busy_b, run_b}, {1'b0, 1'b1, 2'b00});
        35: chk("ar_rehold_end", run_b, 2'b00);
        36: chk("ar_rerun0", {run_b, pc_b}, {2'b01, 32'h304, 32'h300});
        39: chk("ar_rerun1", run_b, 2'b11);
        default: ;
      endcase
      step();
      start_b = 1'b0;
    end
    halt_b = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
